// File: rtl/mem_wb_pkg.sv
// Shared encodings for the MEM/WB stage: load-size codes, FSM states and the
// helper that sizes the byte-offset field from the data width.
package mem_wb_pkg;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_MEM = 2'b01,
    ST_DRAIN    = 2'b10
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_load_align.sv
// Load-return alignment: selects the byte/half lane addressed by the load
// offset and sign- or zero-extends it to the full data width.
module load_align
  import mem_wb_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int OFFW  = clog2(DSIZE / 8)
) (
  input  logic [DSIZE-1:0] rdata,
  input  logic [OFFW-1:0]  offset,
  input  logic [1:0]       size,
  input  logic             is_signed,
  output logic [DSIZE-1:0] data
);

  localparam logic [DSIZE-1:0] MASK_B = DSIZE'(8'hFF);
  localparam logic [DSIZE-1:0] MASK_H = DSIZE'(16'hFFFF);

  logic [OFFW-1:0]  off_h_s;
  logic [DSIZE-1:0] lane_b_s;
  logic [DSIZE-1:0] lane_h_s;
  logic [DSIZE-1:0] fill_b_s;
  logic [DSIZE-1:0] fill_h_s;

  // Lane shift and extension; halfword lanes ignore the offset LSB
  always_comb begin
    off_h_s  = offset & ~OFFW'(1);
    lane_b_s = rdata >> {offset, 3'b000};
    lane_h_s = rdata >> {off_h_s, 3'b000};
    fill_b_s = {DSIZE{is_signed & lane_b_s[7]}};
    fill_h_s = {DSIZE{is_signed & lane_h_s[15]}};
    case (size)
      LD_B:    data = (lane_b_s & MASK_B) | (fill_b_s & ~MASK_B);
      LD_H:    data = (lane_h_s & MASK_H) | (fill_h_s & ~MASK_H);
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: accepts one op per handshake, waits for load data
// when it arrives late, and issues one registered register-file write.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int DSIZE        = 32,
  parameter int ASIZE        = 5,
  parameter int R0_HARDWIRED = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             wen_in,
  input  logic             mem_to_reg_in,
  input  logic [DSIZE-1:0] result_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic [1:0]       ld_size_in,
  input  logic             ld_signed_in,
  input  logic             rdata_valid,
  input  logic [DSIZE-1:0] rdata_in,
  output logic             out_valid,
  output logic             wen_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic [DSIZE-1:0] wdata_out,
  output logic             pend_valid,
  output logic [ASIZE-1:0] pend_waddr,
  output logic             err_unexpected
);

  localparam int OFFW = clog2(DSIZE / 8);

  state_e state_q, state_d;

  logic [ASIZE-1:0] h_waddr_q, h_waddr_d;
  logic             h_wen_q, h_wen_d;
  logic [1:0]       h_size_q, h_size_d;
  logic             h_signed_q, h_signed_d;
  logic [OFFW-1:0]  h_off_q, h_off_d;

  logic             out_valid_q, out_valid_d;
  logic             wen_out_q, wen_out_d;
  logic [ASIZE-1:0] waddr_out_q, waddr_out_d;
  logic [DSIZE-1:0] wdata_out_q, wdata_out_d;
  logic             err_q, err_d;

  logic             cmp_alu_s, cmp_ld_now_s, cmp_hold_s, capture_s, err_set_s;
  logic             idle_s;
  logic [OFFW-1:0]  al_off_s;
  logic [1:0]       al_size_s;
  logic             al_signed_s;
  logic [DSIZE-1:0] al_data_s;

  function automatic logic wb_enable(input logic wen, input logic [ASIZE-1:0] waddr);
    return wen & ~((R0_HARDWIRED != 0) && (waddr == {ASIZE{1'b0}}));
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and event strobes; flush outranks in_valid and rdata_valid
  always_comb begin
    state_d      = state_q;
    cmp_alu_s    = 1'b0;
    cmp_ld_now_s = 1'b0;
    cmp_hold_s   = 1'b0;
    capture_s    = 1'b0;
    err_set_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!flush) begin
          cmp_alu_s    = in_valid & ~mem_to_reg_in;
          cmp_ld_now_s = in_valid & mem_to_reg_in & rdata_valid;
          capture_s    = in_valid & mem_to_reg_in & ~rdata_valid;
          err_set_s    = rdata_valid & ~(in_valid & mem_to_reg_in);
          if (capture_s) begin
            state_d = ST_WAIT_MEM;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (flush) begin
          state_d = rdata_valid ? ST_IDLE : ST_DRAIN;
        end else if (rdata_valid) begin
          cmp_hold_s = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_WAIT_MEM;
        end
      end
      ST_DRAIN: begin
        if (rdata_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    idle_s     = (state_q == ST_IDLE);
    in_ready   = idle_s;
    pend_valid = (state_q == ST_WAIT_MEM);
  end

  // Aligner fed from the live op in IDLE, from the hold registers otherwise
  always_comb begin
    if (idle_s) begin
      al_off_s    = result_in[OFFW-1:0];
      al_size_s   = ld_size_in;
      al_signed_s = ld_signed_in;
    end else begin
      al_off_s    = h_off_q;
      al_size_s   = h_size_q;
      al_signed_s = h_signed_q;
    end
  end

  load_align #(
    .DSIZE(DSIZE),
    .OFFW (OFFW)
  ) u_align (
    .rdata    (rdata_in),
    .offset   (al_off_s),
    .size     (al_size_s),
    .is_signed(al_signed_s),
    .data     (al_data_s)
  );

  // Write-back and hold-register next values
  always_comb begin
    out_valid_d = 1'b0;
    wen_out_d   = 1'b0;
    waddr_out_d = waddr_out_q;
    wdata_out_d = wdata_out_q;
    if (cmp_alu_s) begin
      out_valid_d = 1'b1;
      wen_out_d   = wb_enable(wen_in, waddr_in);
      waddr_out_d = waddr_in;
      wdata_out_d = result_in;
    end else if (cmp_ld_now_s) begin
      out_valid_d = 1'b1;
      wen_out_d   = wb_enable(wen_in, waddr_in);
      waddr_out_d = waddr_in;
      wdata_out_d = al_data_s;
    end else if (cmp_hold_s) begin
      out_valid_d = 1'b1;
      wen_out_d   = wb_enable(h_wen_q, h_waddr_q);
      waddr_out_d = h_waddr_q;
      wdata_out_d = al_data_s;
    end else begin
      out_valid_d = 1'b0;
      wen_out_d   = 1'b0;
    end

    if (capture_s) begin
      h_waddr_d  = waddr_in;
      h_wen_d    = wen_in;
      h_size_d   = ld_size_in;
      h_signed_d = ld_signed_in;
      h_off_d    = result_in[OFFW-1:0];
    end else begin
      h_waddr_d  = h_waddr_q;
      h_wen_d    = h_wen_q;
      h_size_d   = h_size_q;
      h_signed_d = h_signed_q;
      h_off_d    = h_off_q;
    end

    err_d = err_q | err_set_s;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      wen_out_q   <= 1'b0;
      waddr_out_q <= {ASIZE{1'b0}};
      wdata_out_q <= {DSIZE{1'b0}};
      err_q       <= 1'b0;
      h_waddr_q   <= {ASIZE{1'b0}};
      h_wen_q     <= 1'b0;
      h_size_q    <= 2'b00;
      h_signed_q  <= 1'b0;
      h_off_q     <= {OFFW{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      wen_out_q   <= wen_out_d;
      waddr_out_q <= waddr_out_d;
      wdata_out_q <= wdata_out_d;
      err_q       <= err_d;
      h_waddr_q   <= h_waddr_d;
      h_wen_q     <= h_wen_d;
      h_size_q    <= h_size_d;
      h_signed_q  <= h_signed_d;
      h_off_q     <= h_off_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign wen_out        = wen_out_q;
  assign waddr_out      = waddr_out_q;
  assign wdata_out      = wdata_out_q;
  assign pend_waddr     = h_waddr_q;
  assign err_unexpected = err_q;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Self-checking bench for mem_wb_pipe: table-driven single-cycle ops,
// hand-written multi-cycle sequences, then randomized traffic vs a reference model.
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wen_in, mem_to_reg_in, ld_signed_in, rdata_valid;
  logic [31:0] result_in, rdata_in;
  logic [4:0]  waddr_in;
  logic [1:0]  ld_size_in;

  logic        in_ready, out_valid, wen_out, pend_valid, err_unexpected;
  logic [4:0]  waddr_out, pend_waddr;
  logic [31:0] wdata_out;

  logic        in_ready0, out_valid0, wen_out0, pend_valid0, err_unexpected0;
  logic [4:0]  waddr_out0, pend_waddr0;
  logic [31:0] wdata_out0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DSIZE(32), .ASIZE(5), .R0_HARDWIRED(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wen_in(wen_in), .mem_to_reg_in(mem_to_reg_in), .result_in(result_in),
    .waddr_in(waddr_in), .ld_size_in(ld_size_in), .ld_signed_in(ld_signed_in),
    .rdata_valid(rdata_valid), .rdata_in(rdata_in), .out_valid(out_valid),
    .wen_out(wen_out), .waddr_out(waddr_out), .wdata_out(wdata_out),
    .pend_valid(pend_valid), .pend_waddr(pend_waddr), .err_unexpected(err_unexpected));

  mem_wb_pipe #(.DSIZE(32), .ASIZE(5), .R0_HARDWIRED(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .flush(flush),
    .wen_in(wen_in), .mem_to_reg_in(mem_to_reg_in), .result_in(result_in),
    .waddr_in(waddr_in), .ld_size_in(ld_size_in), .ld_signed_in(ld_signed_in),
    .rdata_valid(rdata_valid), .rdata_in(rdata_in), .out_valid(out_valid0),
    .wen_out(wen_out0), .waddr_out(waddr_out0), .wdata_out(wdata_out0),
    .pend_valid(pend_valid0), .pend_waddr(pend_waddr0), .err_unexpected(err_unexpected0));

  // Reference model: one outstanding load at most, described by flags + record
  bit          m_pend, m_drain, m_was_rst;
  logic [4:0]  m_hwaddr;
  logic        m_hwen, m_hsg;
  logic [1:0]  m_hsz;
  logic [31:0] m_haddr;
  logic        e_ov, e_wen, e_wen0, e_err;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  function automatic logic [31:0] ref_align(logic [31:0] rd, logic [31:0] addr,
                                            logic [1:0] sz, logic sg);
    int off;
    logic [31:0] v;
    off = int'(addr % 32'd4);
    case (sz)
      2'd0: begin
        v = (rd >> (off * 8)) & 32'h0000_00FF;
        if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        off = off - (off % 2);
        v = (rd >> (off * 8)) & 32'h0000_FFFF;
        if (sg && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic model_complete(logic [4:0] wa, logic [31:0] wd, logic we);
    e_ov    = 1'b1;
    e_waddr = wa;
    e_wdata = wd;
    e_wen   = we && (wa != 5'd0);
    e_wen0  = we;
  endtask

  task automatic model_update();
    m_was_rst = rst;
    if (rst) begin
      m_pend = 0; m_drain = 0;
      m_hwaddr = 5'd0; m_hwen = 1'b0; m_hsz = 2'd0; m_hsg = 1'b0; m_haddr = 32'd0;
      e_ov = 1'b0; e_wen = 1'b0; e_wen0 = 1'b0; e_err = 1'b0;
      e_waddr = 5'd0; e_wdata = 32'd0;
    end else begin
      e_ov = 1'b0; e_wen = 1'b0; e_wen0 = 1'b0;
      if (!m_pend && !m_drain) begin
        if (!flush) begin
          if (in_valid && !mem_to_reg_in) begin
            model_complete(waddr_in, result_in, wen_in);
            if (rdata_valid) e_err = 1'b1;
          end else if (in_valid && mem_to_reg_in) begin
            if (rdata_valid)
              model_complete(waddr_in, ref_align(rdata_in, result_in, ld_size_in, ld_signed_in), wen_in);
            else begin
              m_pend = 1; m_hwaddr = waddr_in; m_hwen = wen_in;
              m_hsz = ld_size_in; m_hsg = ld_signed_in; m_haddr = result_in;
            end
          end else if (rdata_valid) begin
            e_err = 1'b1;
          end
        end
      end else if (m_pend) begin
        if (flush) begin
          m_pend = 0;
          m_drain = !rdata_valid;
        end else if (rdata_valid) begin
          model_complete(m_hwaddr, ref_align(rdata_in, m_haddr, m_hsz, m_hsg), m_hwen);
          m_pend = 0;
        end
      end else if (rdata_valid) begin
        m_drain = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(e_ov));
    check("wen_out", 64'(wen_out), 64'(e_wen));
    check("wen_out_r0off", 64'(wen_out0), 64'(e_wen0));
    check("waddr_out", 64'(waddr_out), 64'(e_waddr));
    check("wdata_out", 64'(wdata_out), 64'(e_wdata));
    check("in_ready", 64'(in_ready), 64'(!m_pend && !m_drain));
    check("pend_valid", 64'(pend_valid), 64'(m_pend));
    check("err_unexpected", 64'(err_unexpected), 64'(e_err));
    if (m_pend || m_was_rst) check("pend_waddr", 64'(pend_waddr), 64'(m_hwaddr));
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; wen_in = 1'b0; mem_to_reg_in = 1'b0;
    result_in = 32'd0; waddr_in = 5'd0; ld_size_in = 2'd0; ld_signed_in = 1'b0;
    rdata_valid = 1'b0; rdata_in = 32'd0;
  endtask

  task automatic issue_load(logic [31:0] addr, logic [4:0] wa, logic [1:0] sz, logic sg);
    set_idle();
    in_valid = 1'b1; mem_to_reg_in = 1'b1; wen_in = 1'b1;
    result_in = addr; waddr_in = wa; ld_size_in = sz; ld_signed_in = sg;
  endtask

  typedef struct {
    logic        ld;
    logic [1:0]  sz;
    logic        sg;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] res;
    logic [31:0] rd;
    logic        exp_wen;
    logic        exp_wen0;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{1'b0, 2'd0, 1'b0, 1'b1, 5'd5,  32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1, 32'h1234_5678};
    vecs[1]  = '{1'b1, 2'd0, 1'b1, 1'b1, 5'd3,  32'h0000_0103, 32'h80FF_0000, 1'b1, 1'b1, 32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 1'b1, 5'd4,  32'h0000_0102, 32'h80FF_0000, 1'b1, 1'b1, 32'h0000_00FF};
    vecs[3]  = '{1'b1, 2'd1, 1'b1, 1'b1, 5'd6,  32'h0000_0202, 32'h80FF_0000, 1'b1, 1'b1, 32'hFFFF_80FF};
    vecs[4]  = '{1'b1, 2'd1, 1'b1, 1'b1, 5'd9,  32'h0000_0203, 32'h80FF_0000, 1'b1, 1'b1, 32'hFFFF_80FF};
    vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, 5'd10, 32'h0000_0300, 32'h1234_F00D, 1'b1, 1'b1, 32'h0000_F00D};
    vecs[6]  = '{1'b1, 2'd1, 1'b1, 1'b1, 5'd11, 32'h0000_0300, 32'h1234_700D, 1'b1, 1'b1, 32'h0000_700D};
    vecs[7]  = '{1'b1, 2'd2, 1'b0, 1'b1, 5'd12, 32'h0000_0400, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 2'd3, 1'b1, 1'b1, 5'd13, 32'h0000_0401, 32'h8000_0001, 1'b1, 1'b1, 32'h8000_0001};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b1, 5'd0,  32'h0000_00AA, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_00AA};
    vecs[10] = '{1'b1, 2'd0, 1'b1, 1'b0, 5'd14, 32'h0000_0100, 32'h0000_007F, 1'b0, 1'b0, 32'h0000_007F};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF};

    set_idle();
    rst = 1'b1;
    step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_wdata", 64'(wdata_out), 64'd0);

    // Single-cycle ops from IDLE, each followed by an idle cycle
    for (int i = 0; i < 12; i++) begin
      set_idle();
      in_valid = 1'b1; mem_to_reg_in = vecs[i].ld; ld_size_in = vecs[i].sz;
      ld_signed_in = vecs[i].sg; wen_in = vecs[i].wen; waddr_in = vecs[i].wa;
      result_in = vecs[i].res; rdata_in = vecs[i].rd; rdata_valid = vecs[i].ld;
      step();
      check("vec_out_valid", 64'(out_valid), 64'd1);
      check("vec_wen", 64'(wen_out), 64'(vecs[i].exp_wen));
      check("vec_wen_r0off", 64'(wen_out0), 64'(vecs[i].exp_wen0));
      check("vec_waddr", 64'(waddr_out), 64'(vecs[i].wa));
      check("vec_wdata", 64'(wdata_out), 64'(vecs[i].exp_wdata));
      check("vec_in_ready", 64'(in_ready), 64'd1);
      set_idle();
      step();
      check("vec_idle_out_valid", 64'(out_valid), 64'd0);
    end

    // Delayed LHU; unrelated ops offered while waiting must not be taken
    issue_load(32'h0000_0202, 5'd7, 2'd1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("lhu_in_ready", 64'(in_ready), 64'd0);
      check("lhu_pend_valid", 64'(pend_valid), 64'd1);
      check("lhu_pend_waddr", 64'(pend_waddr), 64'd7);
      set_idle();
      in_valid = 1'b1; wen_in = 1'b1; waddr_in = 5'd20; result_in = 32'h5555_5555;
      if (i == 2) begin
        rdata_valid = 1'b1; rdata_in = 32'hBEEF_0001;
      end
      step();
    end
    check("lhu_wdata", 64'(wdata_out), 64'h0000_BEEF);
    check("lhu_wen", 64'(wen_out), 64'd1);
    check("lhu_waddr", 64'(waddr_out), 64'd7);

    // Flush while waiting -> drain; late data discarded, flush ignored in drain
    issue_load(32'h0000_0100, 5'd8, 2'd2, 1'b0);
    step();
    set_idle(); flush = 1'b1;
    step();
    check("drain_in_ready", 64'(in_ready), 64'd0);
    check("drain_pend", 64'(pend_valid), 64'd0);
    set_idle(); flush = 1'b1;
    step();
    set_idle(); rdata_valid = 1'b1; rdata_in = 32'h1111_2222;
    step();
    check("drain_out_valid", 64'(out_valid), 64'd0);
    check("drain_back_idle", 64'(in_ready), 64'd1);
    check("drain_no_err", 64'(err_unexpected), 64'd0);

    // Flush coincident with data goes straight back to IDLE
    issue_load(32'h0000_0100, 5'd9, 2'd2, 1'b0);
    step();
    set_idle(); flush = 1'b1; rdata_valid = 1'b1; rdata_in = 32'h3333_4444;
    step();
    check("flushrd_out_valid", 64'(out_valid), 64'd0);
    check("flushrd_in_ready", 64'(in_ready), 64'd1);

    // Unexpected data sets the sticky error; reset mid-wait clears everything
    set_idle(); rdata_valid = 1'b1;
    step();
    check("err_set", 64'(err_unexpected), 64'd1);
    set_idle();
    step(); step();
    check("err_sticky", 64'(err_unexpected), 64'd1);
    issue_load(32'h0000_0000, 5'd12, 2'd2, 1'b0);
    step();
    set_idle(); rst = 1'b1;
    step();
    check("rstw_pend", 64'(pend_valid), 64'd0);
    check("rstw_err", 64'(err_unexpected), 64'd0);
    check("rstw_pend_waddr", 64'(pend_waddr), 64'd0);
    set_idle(); rdata_valid = 1'b1;
    step();
    check("rstw_late_err", 64'(err_unexpected), 64'd1);

    // Randomized traffic against the model
    set_idle(); rst = 1'b1;
    step();
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      in_valid      = $urandom_range(0, 1);
      mem_to_reg_in = $urandom_range(0, 1);
      wen_in        = ($urandom_range(0, 3) != 0);
      waddr_in      = 5'($urandom_range(0, 31));
      result_in     = $urandom;
      ld_size_in    = 2'($urandom_range(0, 3));
      ld_signed_in  = $urandom_range(0, 1);
      rdata_in      = $urandom;
      if (m_pend || m_drain)
        rdata_valid = ($urandom_range(0, 2) == 0);
      else if (in_valid && mem_to_reg_in)
        rdata_valid = $urandom_range(0, 1);
      else
        rdata_valid = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
